// File: rtl/sdp_pipe.sv
// sdp_pipe: simple dual-port RAM with valid/ready ports, byte-lane writes,
// a 1- or 2-stage read pipeline, selectable read-during-write policy and a
// credit-managed show-ahead output FIFO.
module sdp_pipe #(
    parameter int W_DATA   = 16,
    parameter int W_ADDR   = 10,
    parameter int DEPTH    = 1024,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0,
    parameter int W_BE     = W_DATA / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          wr_addr_data_ready,
    input  logic                          wr_addr_data_valid,
    input  logic [W_BE+W_DATA+W_ADDR-1:0] wr_addr_data_data,
    output logic                          rd_addr_ready,
    input  logic                          rd_addr_valid,
    input  logic [W_ADDR-1:0]             rd_addr_data,
    input  logic                          rd_data_ready,
    output logic                          rd_data_valid,
    output logic [W_DATA-1:0]             rd_data_data
);

    localparam int FD = RD_LAT + 2;
    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD + 1);
    localparam logic [CW-1:0]   FD_C    = CW'(FD);
    localparam logic [W_ADDR:0] DEPTH_C = (W_ADDR + 1)'(DEPTH);
    localparam logic            WF      = (RDW_MODE == 1);

    // Advance a FIFO pointer with wrap at FD entries.
    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    logic [W_DATA-1:0] mem_q [DEPTH];
    logic [W_DATA-1:0] fifo_mem_q [FD];

    logic              wr_rdy_q, rd_rdy_q;
    logic [CW-1:0]     credit_q, credit_d, cnt_q, cnt_d;
    logic [PW-1:0]     wptr_q, rptr_q;
    logic              s1_vld_q, s1_coll_q;
    logic [W_DATA-1:0] s1_rdata_q, s1_wdata_q, s1_merged_s;
    logic [W_BE-1:0]   s1_be_q;
    logic              last_vld_s;
    logic [W_DATA-1:0] last_data_s;

    logic [W_ADDR-1:0] wr_addr_s;
    logic [W_DATA-1:0] wr_wdata_s;
    logic [W_BE-1:0]   wr_be_s;
    logic              wr_fire_s, wr_in_s, rd_fire_s, rd_in_s, pop_s, coll_s;

    assign wr_addr_s  = wr_addr_data_data[W_ADDR-1:0];
    assign wr_wdata_s = wr_addr_data_data[W_ADDR+W_DATA-1:W_ADDR];
    assign wr_be_s    = wr_addr_data_data[W_ADDR+W_DATA+W_BE-1:W_ADDR+W_DATA];
    assign wr_fire_s  = wr_addr_data_valid & wr_rdy_q;
    assign wr_in_s    = ({1'b0, wr_addr_s} < DEPTH_C);
    assign rd_fire_s  = rd_addr_valid & rd_rdy_q;
    assign rd_in_s    = ({1'b0, rd_addr_data} < DEPTH_C);
    assign pop_s      = (cnt_q != {CW{1'b0}}) & rd_data_ready;
    assign coll_s     = wr_fire_s & rd_fire_s & wr_in_s & rd_in_s &
                        (wr_addr_s == rd_addr_data) & (wr_be_s != {W_BE{1'b0}});

    assign wr_addr_data_ready = wr_rdy_q;
    assign rd_addr_ready      = rd_rdy_q;
    assign rd_data_valid      = (cnt_q != {CW{1'b0}});
    assign rd_data_data       = fifo_mem_q[rptr_q];

    // Array write per byte lane and read capture; the read sees pre-write data.
    always_ff @(posedge clk) begin
        if (wr_fire_s && wr_in_s) begin
            for (int i = 0; i < W_BE; i++) begin
                if (wr_be_s[i]) mem_q[wr_addr_s][8*i +: 8] <= wr_wdata_s[8*i +: 8];
            end
        end
        if (rd_fire_s) begin
            s1_rdata_q <= rd_in_s ? mem_q[rd_addr_data] : {W_DATA{1'b0}};
            s1_wdata_q <= wr_wdata_s;
            s1_be_q    <= wr_be_s;
        end
    end

    // Stage-1 valid and collision flag; collisions only matter in write-first mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_coll_q <= 1'b0;
        end else begin
            s1_vld_q  <= rd_fire_s;
            s1_coll_q <= coll_s & WF;
        end
    end

    // Write-first merge at the array output: new bytes on enabled lanes.
    always_comb begin
        s1_merged_s = s1_rdata_q;
        if (s1_coll_q) begin
            for (int i = 0; i < W_BE; i++) begin
                if (s1_be_q[i]) s1_merged_s[8*i +: 8] = s1_wdata_q[8*i +: 8];
            end
        end else begin
            s1_merged_s = s1_rdata_q;
        end
    end

    if (RD_LAT == 2) begin : g_s2
        logic              s2_vld_q;
        logic [W_DATA-1:0] s2_data_q;

        // Output register stage valid bit.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) s2_vld_q <= 1'b0;
            else      s2_vld_q <= s1_vld_q;
        end

        // Output register stage data.
        always_ff @(posedge clk) begin
            if (s1_vld_q) s2_data_q <= s1_merged_s;
        end

        assign last_vld_s  = s2_vld_q;
        assign last_data_s = s2_data_q;
    end else begin : g_s1
        assign last_vld_s  = s1_vld_q;
        assign last_data_s = s1_merged_s;
    end

    // Next credit and FIFO occupancy from issue/push and pop events.
    always_comb begin
        credit_d = credit_q;
        cnt_d    = cnt_q;
        case ({rd_fire_s, pop_s})
            2'b10:   credit_d = credit_q + CW'(1);
            2'b01:   credit_d = credit_q - CW'(1);
            default: credit_d = credit_q;
        endcase
        case ({last_vld_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Readies, credit counter and FIFO pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_rdy_q <= 1'b0;
            rd_rdy_q <= 1'b0;
            credit_q <= {CW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            wptr_q   <= {PW{1'b0}};
            rptr_q   <= {PW{1'b0}};
        end else begin
            wr_rdy_q <= 1'b1;
            rd_rdy_q <= (credit_d < FD_C);
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            if (last_vld_s) wptr_q <= inc_ptr(wptr_q);
            if (pop_s)      rptr_q <= inc_ptr(rptr_q);
        end
    end

    // FIFO storage; the credit scheme keeps pushes from overrunning the head.
    always_ff @(posedge clk) begin
        if (last_vld_s) fifo_mem_q[wptr_q] <= last_data_s;
    end

endmodule

// File: tb/tb_sdp_pipe.sv
// Directed bench for sdp_pipe. Two instances share stimulus:
//   u_a: RD_LAT=1, RDW_MODE=0 (read-first), DEPTH=1000
//   u_b: RD_LAT=2, RDW_MODE=1 (write-first), DEPTH=1024
module tb_sdp_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [27:0] wr_payload;
    logic        rd_valid;
    logic [9:0]  rd_addr;
    logic        rd_rdy;

    logic        a_wr_rdy, a_rd_rdy, a_vld;
    logic [15:0] a_data;
    logic        b_wr_rdy, b_rd_rdy, b_vld;
    logic [15:0] b_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdp_pipe #(.W_DATA(16), .W_ADDR(10), .DEPTH(1000), .RD_LAT(1), .RDW_MODE(0)) u_a (
        .clk(clk), .rst(rst),
        .wr_addr_data_ready(a_wr_rdy), .wr_addr_data_valid(wr_valid), .wr_addr_data_data(wr_payload),
        .rd_addr_ready(a_rd_rdy), .rd_addr_valid(rd_valid), .rd_addr_data(rd_addr),
        .rd_data_ready(rd_rdy), .rd_data_valid(a_vld), .rd_data_data(a_data)
    );

    sdp_pipe #(.W_DATA(16), .W_ADDR(10), .DEPTH(1024), .RD_LAT(2), .RDW_MODE(1)) u_b (
        .clk(clk), .rst(rst),
        .wr_addr_data_ready(b_wr_rdy), .wr_addr_data_valid(wr_valid), .wr_addr_data_data(wr_payload),
        .rd_addr_ready(b_rd_rdy), .rd_addr_valid(rd_valid), .rd_addr_data(rd_addr),
        .rd_data_ready(rd_rdy), .rd_data_valid(b_vld), .rd_data_data(b_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_payload = {be, d, a};
        wr_valid   = 1'b1;
        step();
        wr_valid   = 1'b0;
    endtask

    // Wait (bounded) for one returned word on each instance and compare it.
    task automatic collect(input string tag, input logic [15:0] exp_a, input logic [15:0] exp_b);
        logic        ga = 1'b0, gb = 1'b0;
        logic [15:0] da = 16'h0, db = 16'h0;
        for (int i = 0; i < 10; i++) begin
            if (a_vld && !ga) begin ga = 1'b1; da = a_data; end
            if (b_vld && !gb) begin gb = 1'b1; db = b_data; end
            step();
        end
        check({tag, "_a_seen"}, {31'd0, ga}, 32'd1);
        check({tag, "_a_data"}, {16'd0, da}, {16'd0, exp_a});
        check({tag, "_b_seen"}, {31'd0, gb}, 32'd1);
        check({tag, "_b_data"}, {16'd0, db}, {16'd0, exp_b});
    endtask

    task automatic rd_chk(input string tag, input logic [9:0] a,
                          input logic [15:0] exp_a, input logic [15:0] exp_b);
        rd_valid = 1'b1;
        rd_addr  = a;
        step();
        rd_valid = 1'b0;
        collect(tag, exp_a, exp_b);
    endtask

    initial begin
        int a_acc, b_acc;
        logic seen;
        rst = 1'b1; wr_valid = 1'b0; wr_payload = 28'd0;
        rd_valid = 1'b0; rd_addr = 10'd0; rd_rdy = 1'b1;
        #2 rst = 1'b0;

        // Reset / idle
        repeat (5) step();
        check("rst_a_wrdy", {31'd0, a_wr_rdy}, 32'd0);
        check("rst_a_rrdy", {31'd0, a_rd_rdy}, 32'd0);
        check("rst_a_vld",  {31'd0, a_vld},    32'd0);
        check("rst_b_wrdy", {31'd0, b_wr_rdy}, 32'd0);
        check("rst_b_rrdy", {31'd0, b_rd_rdy}, 32'd0);
        check("rst_b_vld",  {31'd0, b_vld},    32'd0);
        rst = 1'b1;
        step();
        check("rel_a_wrdy", {31'd0, a_wr_rdy}, 32'd1);
        check("rel_a_rrdy", {31'd0, a_rd_rdy}, 32'd1);
        check("rel_b_wrdy", {31'd0, b_wr_rdy}, 32'd1);
        check("rel_b_rrdy", {31'd0, b_rd_rdy}, 32'd1);

        // Basic write/read with exact latency
        wr(10'd5, 16'hBEEF, 2'b11);
        rd_valid = 1'b1; rd_addr = 10'd5;
        step();                                   // cycle 1
        rd_valid = 1'b0;
        check("lat_c1_a_vld", {31'd0, a_vld}, 32'd0);
        check("lat_c1_b_vld", {31'd0, b_vld}, 32'd0);
        step();                                   // cycle 2
        check("lat_c2_a_vld",  {31'd0, a_vld}, 32'd1);
        check("lat_c2_a_data", {16'd0, a_data}, 32'h0000BEEF);
        check("lat_c2_b_vld",  {31'd0, b_vld}, 32'd0);
        step();                                   // cycle 3
        check("lat_c3_a_vld",  {31'd0, a_vld}, 32'd0);
        check("lat_c3_b_vld",  {31'd0, b_vld}, 32'd1);
        check("lat_c3_b_data", {16'd0, b_data}, 32'h0000BEEF);
        step();
        check("lat_c4_b_vld",  {31'd0, b_vld}, 32'd0);

        // Byte enables
        wr(10'd3, 16'h1234, 2'b11);
        wr(10'd3, 16'hAB00, 2'b10);
        rd_chk("be", 10'd3, 16'hAB34, 16'hAB34);
        wr(10'd3, 16'hFFFF, 2'b00);
        rd_chk("be_none", 10'd3, 16'hAB34, 16'hAB34);

        // Read-during-write
        wr(10'd7, 16'h1111, 2'b11);
        wr_payload = {2'b01, 16'h2222, 10'd7};
        wr_valid = 1'b1; rd_valid = 1'b1; rd_addr = 10'd7;
        step();
        wr_valid = 1'b0; rd_valid = 1'b0;
        collect("rdw", 16'h1111, 16'h1122);
        rd_chk("rdw_after", 10'd7, 16'h1122, 16'h1122);

        // Out of range (1000 is out of range for u_a only)
        wr(10'd1000, 16'h5555, 2'b11);
        rd_chk("oor", 10'd1000, 16'h0000, 16'h5555);

        // Back-pressure
        for (int k = 10; k < 14; k++) wr(10'(k), 16'hC000 + 16'(k), 2'b11);
        rd_rdy = 1'b0;
        a_acc = 0; b_acc = 0;
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1;
            rd_addr  = 10'd10 + 10'(i);
            if (a_rd_rdy) a_acc++;
            if (b_rd_rdy) b_acc++;
            step();
        end
        rd_valid = 1'b0;
        repeat (4) step();
        check("bp_a_acc",  a_acc, 32'd3);
        check("bp_b_acc",  b_acc, 32'd4);
        check("bp_a_rrdy", {31'd0, a_rd_rdy}, 32'd0);
        check("bp_b_rrdy", {31'd0, b_rd_rdy}, 32'd0);
        check("bp_a_head", {15'd0, a_vld, a_data}, 32'h0001C00A);
        check("bp_b_head", {15'd0, b_vld, b_data}, 32'h0001C00A);
        step();
        check("bp_a_hold", {15'd0, a_vld, a_data}, 32'h0001C00A);
        check("bp_b_hold", {15'd0, b_vld, b_data}, 32'h0001C00A);
        rd_rdy = 1'b1;
        step();
        check("dr1_a",      {15'd0, a_vld, a_data}, 32'h0001C00B);
        check("dr1_b",      {15'd0, b_vld, b_data}, 32'h0001C00B);
        check("dr1_a_rrdy", {31'd0, a_rd_rdy}, 32'd1);
        check("dr1_b_rrdy", {31'd0, b_rd_rdy}, 32'd1);
        step();
        check("dr2_a", {15'd0, a_vld, a_data}, 32'h0001C00C);
        check("dr2_b", {15'd0, b_vld, b_data}, 32'h0001C00C);
        step();
        check("dr3_a_vld", {31'd0, a_vld}, 32'd0);
        check("dr3_b",     {15'd0, b_vld, b_data}, 32'h0001C00D);
        step();
        check("dr4_b_vld", {31'd0, b_vld}, 32'd0);

        // Reset mid-flight discards in-flight reads
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1'b1;
            rd_addr  = 10'd10 + 10'(i);
            step();
        end
        rd_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mrst_a_vld",  {31'd0, a_vld},    32'd0);
        check("mrst_b_vld",  {31'd0, b_vld},    32'd0);
        check("mrst_a_rrdy", {31'd0, a_rd_rdy}, 32'd0);
        check("mrst_b_wrdy", {31'd0, b_wr_rdy}, 32'd0);
        repeat (3) step();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | a_vld | b_vld;
        end
        check("mrst_no_data", {31'd0, seen}, 32'd0);
        check("mrst_rel_a",   {30'd0, a_rd_rdy, a_wr_rdy}, 32'd3);
        check("mrst_rel_b",   {30'd0, b_rd_rdy, b_wr_rdy}, 32'd3);
        rd_chk("post_rst", 10'd5, 16'hBEEF, 16'hBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
